// File: rtl/vt_pkg.sv
// Shared types and elaboration helpers for the VT encoder and its stream controller.
package vt_pkg;

   typedef enum logic [1:0] {IDLE, ENC, SHIFT} vt_ctrl_state_t;

   function automatic int vt_cnt_w(input int n);
      return $clog2(n);
   endfunction

   // Check bits sit at power-of-two positions (1-based, position 1 is the codeword MSB).
   function automatic bit vt_is_check_pos(input int i);
      return (i > 0) && ((i & (i - 1)) == 0);
   endfunction

   // Index of the message bit carried at non-check position i.
   function automatic int vt_data_idx(input int i);
      int c;
      c = 0;
      for (int p = 1; p < i; p++)
         if (!vt_is_check_pos(p)) c++;
      return c;
   endfunction

endpackage

// File: rtl/vt_encode.sv
// Combinational systematic VT encoder: message bits fill non-power-of-two positions,
// check bits at power-of-two positions make sum(i*x_i) mod (n+1) hit SYNDROME_VAL.
module vt_encode
   import vt_pkg::*;
#(
   parameter int k            = 5,
   parameter int n            = 10,
   parameter int SYNDROME_VAL = 0
) (
   input  logic [k-1:0] data_in,
   output logic [n-1:0] codeword,
   output logic         good_syndrome
);

   localparam int M = n + 1;

   logic [n:1] xd;
   logic [n:1] xc;
   int         data_sum;
   int         def;
   int         syn;

   for (genvar i = 1; i <= n; i++) begin : g_pos
      if (vt_is_check_pos(i)) begin : g_chk
         assign xd[i] = 1'b0;
         assign xc[i] = def[$clog2(i)];
      end else begin : g_dat
         localparam int DI = vt_data_idx(i);
         assign xc[i] = 1'b0;
         if (DI < k) begin : g_use
            assign xd[i] = data_in[k-1-DI];
         end else begin : g_pad
            assign xd[i] = 1'b0;
         end
      end
      assign codeword[n-i] = xd[i] | xc[i];
   end

   always_comb begin
      data_sum = 0;
      for (int i = 1; i <= n; i++)
         if (xd[i]) data_sum = data_sum + i;
   end

   // The deficiency is always < n+1, so the binary check bits can always reach it.
   assign def = ((SYNDROME_VAL % M) + M - (data_sum % M)) % M;

   always_comb begin
      syn = 0;
      for (int i = 1; i <= n; i++)
         if (codeword[n-i]) syn = syn + i;
   end

   assign good_syndrome = ((syn % M) == SYNDROME_VAL);

endmodule

// File: rtl/vt_encode_stream_ctrl.sv
// Accepts message words, encodes them through vt_encode and streams each codeword
// out MSB-first; bad-syndrome words are dropped and counted.
module vt_encode_stream_ctrl
   import vt_pkg::*;
#(
   parameter int k            = 5,
   parameter int n            = 10,
   parameter int SYNDROME_VAL = 0,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic [k-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             err_pulse,
   output logic [CNT_W-1:0] ok_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int BW = vt_cnt_w(n);

   if (k >= n) begin : g_param_chk
      $error("vt_encode_stream_ctrl: k must be smaller than n");
   end

   vt_ctrl_state_t   state_q, state_d;
   logic [k-1:0]     enc_in_q, enc_in_d;
   logic [n-1:0]     sh_q, sh_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             err_pulse_q, err_pulse_d;
   logic [n-1:0]     enc_cw;
   logic             enc_good;

   vt_encode #(.k(k), .n(n), .SYNDROME_VAL(SYNDROME_VAL)) u_enc (
      .data_in      (enc_in_q),
      .codeword     (enc_cw),
      .good_syndrome(enc_good)
   );

   // abort in IDLE blocks acceptance in the same cycle
   assign in_ready  = in_ready_q & ~abort;
   assign out_bit   = sh_q[n-1];
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign err_pulse = err_pulse_q;
   assign ok_cnt    = ok_cnt_q;
   assign err_cnt   = err_cnt_q;

   always_comb begin
      state_d     = state_q;
      enc_in_d    = enc_in_q;
      sh_d        = sh_q;
      bit_cnt_d   = bit_cnt_q;
      ok_cnt_d    = ok_cnt_q;
      err_cnt_d   = err_cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      err_pulse_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               enc_in_d   = in_data;
               in_ready_d = 1'b0;
               state_d    = ENC;
            end
         end
         ENC: begin
            if (abort) begin
               state_d    = IDLE;
               in_ready_d = 1'b1;
            end else if (enc_good) begin
               sh_d        = enc_cw;
               bit_cnt_d   = BW'(n - 1);
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               state_d     = SHIFT;
            end else begin
               err_pulse_d = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         SHIFT: begin
            if (abort) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end else if (out_ready) begin
               sh_d      = {sh_q[n-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - 1'b1;
               if (bit_cnt_q == '0) begin
                  if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 1'b1;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = IDLE;
               end else begin
                  out_last_d = (bit_cnt_q == BW'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         enc_in_q    <= '0;
         sh_q        <= '0;
         bit_cnt_q   <= '0;
         ok_cnt_q    <= '0;
         err_cnt_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         enc_in_q    <= enc_in_d;
         sh_q        <= sh_d;
         bit_cnt_q   <= bit_cnt_d;
         ok_cnt_q    <= ok_cnt_d;
         err_cnt_q   <= err_cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_pulse_q <= err_pulse_d;
      end
   end

endmodule

// File: tb/tb_vt_encode_stream_ctrl.sv
// Bench for vt_encode_stream_ctrl: main instance (k=5,n=10), a 2-bit-counter instance
// for saturation, and an instance with an unreachable syndrome target for the drop path.
module tb_vt_encode_stream_ctrl;

   localparam int K = 5;
   localparam int N = 10;

   logic clk = 1'b0;
   logic rst_n, abort, in_valid, out_ready;
   logic [K-1:0] in_data;

   logic in_ready, out_bit, out_valid, out_last, err_pulse;
   logic [15:0] ok_cnt, err_cnt;
   logic s_in_ready, s_out_bit, s_out_valid, s_out_last, s_err_pulse;
   logic [1:0] s_ok_cnt, s_err_cnt;
   logic b_in_ready, b_out_bit, b_out_valid, b_out_last, b_err_pulse;
   logic [1:0] b_ok_cnt, b_err_cnt;

   int n_chk = 0;
   int n_pass = 0;
   int exp_ok = 0;

   always #5 clk = ~clk;

   vt_encode_stream_ctrl #(.k(K), .n(N), .SYNDROME_VAL(0), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .err_pulse(err_pulse), .ok_cnt(ok_cnt), .err_cnt(err_cnt));

   vt_encode_stream_ctrl #(.k(K), .n(N), .SYNDROME_VAL(0), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .abort(abort), .in_data(in_data), .in_valid(in_valid),
      .in_ready(s_in_ready), .out_bit(s_out_bit), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_last(s_out_last), .err_pulse(s_err_pulse), .ok_cnt(s_ok_cnt), .err_cnt(s_err_cnt));

   vt_encode_stream_ctrl #(.k(K), .n(N), .SYNDROME_VAL(N + 1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .abort(abort), .in_data(in_data), .in_valid(in_valid),
      .in_ready(b_in_ready), .out_bit(b_out_bit), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_last(b_out_last), .err_pulse(b_err_pulse), .ok_cnt(b_ok_cnt), .err_cnt(b_err_cnt));

   // Golden VT codeword: message in non-power-of-two positions, then search the smallest
   // check value whose binary weights bring sum(i*x_i) to 0 mod (N+1).
   function automatic logic [N-1:0] gold(input logic [K-1:0] m);
      int x[N+1];
      int j, s;
      logic [N-1:0] r;
      r = '0;
      j = 0;
      for (int i = 0; i <= N; i++) x[i] = 0;
      for (int i = 1; i <= N; i++)
         if ((i & (i - 1)) != 0) begin
            if (j < K) x[i] = int'(m[K-1-j]);
            j++;
         end
      for (int d = 0; d < 16; d++) begin
         s = 0;
         for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) == 0) x[i] = ((d & i) != 0) ? 1 : 0;
            s += i * x[i];
         end
         if (s % (N + 1) == 0) begin
            for (int i = 1; i <= N; i++) r[N-i] = x[i][0];
            return r;
         end
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step(); step();
      rst_n = 1'b1;
   endtask

   // Sends one word and drains it; offsets are cycles after the accepting edge.
   task automatic xfer_word(input logic [K-1:0] data, input int mode, input int abort_at,
                            output logic [N-1:0] got, output int nx, output int last_pos,
                            output int first_vld, output int done_cyc, output bit stable_ok,
                            output bit tmo);
      int w;
      bit prev_stall;
      logic pb, pl;
      got = '0; nx = 0; last_pos = -1; first_vld = -1; done_cyc = -1;
      stable_ok = 1'b1; tmo = 1'b0; prev_stall = 1'b0; pb = 1'b0; pl = 1'b0;
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      if (!in_ready) begin tmo = 1'b1; return; end
      in_data = data; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 1; c < 100; c++) begin
         if (c >= 2 && in_ready) begin done_cyc = c; break; end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid && first_vld < 0) first_vld = c;
         if (prev_stall && (!out_valid || out_bit !== pb || out_last !== pl)) stable_ok = 1'b0;
         abort = (abort_at >= 0 && nx == abort_at && out_valid);
         if (out_valid && out_ready && !abort) begin
            got = {got[N-2:0], out_bit};
            if (out_last) last_pos = (last_pos == -1) ? nx : -2;
            nx++;
         end
         prev_stall = out_valid && !out_ready;
         pb = out_bit; pl = out_last;
         step();
         abort = 1'b0;
      end
      out_ready = 1'b0;
      if (done_cyc < 0) tmo = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; abort = 1'b1; in_valid = 1'b1; in_data = 5'b11011; out_ready = 1'b1;
      step(); step();
      rst_n = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else n_pass++;
      n_chk++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse got %b exp 0", err_pulse); else n_pass++;
      n_chk++; if (out_bit !== 1'b0) $display("FAIL reset_out_bit got %b exp 0", out_bit); else n_pass++;
      n_chk++; if (ok_cnt !== 16'd0) $display("FAIL reset_ok_cnt got %0d exp 0", ok_cnt); else n_pass++;
      n_chk++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); else n_pass++;
      exp_ok = 0;
   endtask

   task automatic test_single();
      logic [K-1:0] d;
      logic [N-1:0] got;
      int nx, lp, fv, dc;
      bit st, tmo;
      for (int w = 0; w < 4; w++) begin
         d = (w == 0) ? 5'b11011 : K'($urandom_range(0, 31));
         xfer_word(d, 0, -1, got, nx, lp, fv, dc, st, tmo);
         exp_ok++;
         n_chk++; if (tmo !== 1'b0) $display("FAIL single_timeout word %0d", w); else n_pass++;
         n_chk++; if (got !== gold(d)) $display("FAIL single_stream data %b got %b exp %b", d, got, gold(d)); else n_pass++;
         n_chk++; if (nx != N) $display("FAIL single_nbits got %0d exp %0d", nx, N); else n_pass++;
         n_chk++; if (lp != N - 1) $display("FAIL single_last_pos got %0d exp %0d", lp, N - 1); else n_pass++;
         n_chk++; if (fv != 2) $display("FAIL single_first_valid got %0d exp 2", fv); else n_pass++;
         n_chk++; if (dc != N + 2) $display("FAIL single_ready_back got %0d exp %0d", dc, N + 2); else n_pass++;
         n_chk++; if (ok_cnt !== 16'(exp_ok)) $display("FAIL single_ok_cnt got %0d exp %0d", ok_cnt, exp_ok); else n_pass++;
      end
   endtask

   task automatic test_stall();
      logic [K-1:0] d;
      logic [N-1:0] got;
      int nx, lp, fv, dc;
      bit st, tmo;
      for (int w = 0; w < 3; w++) begin
         d = (w == 0) ? 5'b11011 : K'($urandom_range(0, 31));
         xfer_word(d, (w == 0) ? 1 : 2, -1, got, nx, lp, fv, dc, st, tmo);
         exp_ok++;
         n_chk++; if (tmo !== 1'b0) $display("FAIL stall_timeout word %0d", w); else n_pass++;
         n_chk++; if (st !== 1'b1) $display("FAIL stall_stable word %0d got unstable exp stable", w); else n_pass++;
         n_chk++; if (got !== gold(d)) $display("FAIL stall_stream data %b got %b exp %b", d, got, gold(d)); else n_pass++;
         n_chk++; if (nx != N) $display("FAIL stall_nbits got %0d exp %0d", nx, N); else n_pass++;
         n_chk++; if (lp != N - 1) $display("FAIL stall_last_pos got %0d exp %0d", lp, N - 1); else n_pass++;
         n_chk++; if (ok_cnt !== 16'(exp_ok)) $display("FAIL stall_ok_cnt got %0d exp %0d", ok_cnt, exp_ok); else n_pass++;
      end
   endtask

   task automatic test_bad_syndrome();
      int pulses, pulse_at, rdy2, w;
      bit saw_valid, main_pulse;
      do_reset();
      in_data = K'($urandom_range(0, 31)); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_chk++; if (b_in_ready !== 1'b0) $display("FAIL bad_ready_enc got %b exp 0", b_in_ready); else n_pass++;
      pulses = 0; pulse_at = -1; rdy2 = -1; saw_valid = 1'b0; main_pulse = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (b_err_pulse) begin pulses++; if (pulse_at < 0) pulse_at = c; end
         if (b_out_valid) saw_valid = 1'b1;
         if (err_pulse) main_pulse = 1'b1;
         if (c == 2) rdy2 = int'(b_in_ready);
         step();
      end
      n_chk++; if (pulses != 1) $display("FAIL bad_pulse_count got %0d exp 1", pulses); else n_pass++;
      n_chk++; if (pulse_at != 2) $display("FAIL bad_pulse_cycle got %0d exp 2", pulse_at); else n_pass++;
      n_chk++; if (saw_valid !== 1'b0) $display("FAIL bad_out_valid got 1 exp 0"); else n_pass++;
      n_chk++; if (rdy2 != 1) $display("FAIL bad_ready_back got %0d exp 1", rdy2); else n_pass++;
      n_chk++; if (b_err_cnt !== 2'd1) $display("FAIL bad_err_cnt got %0d exp 1", b_err_cnt); else n_pass++;
      n_chk++; if (main_pulse !== 1'b0) $display("FAIL good_no_err_pulse got 1 exp 0"); else n_pass++;

      // abort during ENC suppresses the pulse and the count
      do_reset();
      in_data = K'($urandom_range(0, 31)); in_valid = 1'b1;
      step();
      in_valid = 1'b0; abort = 1'b1;
      pulses = 0;
      step();
      abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (b_err_pulse) pulses++;
         step();
      end
      n_chk++; if (pulses != 0) $display("FAIL abort_enc_pulse got %0d exp 0", pulses); else n_pass++;
      n_chk++; if (b_err_cnt !== 2'd0) $display("FAIL abort_enc_err_cnt got %0d exp 0", b_err_cnt); else n_pass++;

      // five drops into a 2-bit counter saturate at 3
      for (int k2 = 0; k2 < 5; k2++) begin
         w = 0;
         while (!b_in_ready && w < 20) begin step(); w++; end
         in_data = K'($urandom_range(0, 31)); in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         step(); step();
      end
      n_chk++; if (b_err_cnt !== 2'd3) $display("FAIL err_cnt_saturate got %0d exp 3", b_err_cnt); else n_pass++;
   endtask

   task automatic test_abort();
      logic [K-1:0] d;
      logic [N-1:0] got, g;
      int nx, lp, fv, dc;
      bit st, tmo;
      do_reset();
      d = K'($urandom_range(0, 31));
      g = gold(d);
      xfer_word(d, 0, 4, got, nx, lp, fv, dc, st, tmo);
      n_chk++; if (tmo !== 1'b0) $display("FAIL abort_timeout"); else n_pass++;
      n_chk++; if (nx != 4) $display("FAIL abort_nbits got %0d exp 4", nx); else n_pass++;
      n_chk++; if (got[3:0] !== g[N-1:N-4]) $display("FAIL abort_prefix got %b exp %b", got[3:0], g[N-1:N-4]); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL abort_valid_drop got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (ok_cnt !== 16'd0) $display("FAIL abort_ok_cnt got %0d exp 0", ok_cnt); else n_pass++;

      // abort in IDLE: the offered word must not be taken
      abort = 1'b1; in_valid = 1'b1; in_data = K'($urandom_range(0, 31));
      #1;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL abort_idle_ready got %b exp 0", in_ready); else n_pass++;
      step();
      abort = 1'b0; in_valid = 1'b0;
      #1;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL abort_idle_no_accept got %b exp 1", in_ready); else n_pass++;

      xfer_word(5'b00101, 0, -1, got, nx, lp, fv, dc, st, tmo);
      n_chk++; if (got !== gold(5'b00101) || nx != N) $display("FAIL abort_next_word got %b/%0d exp %b/%0d", got, nx, gold(5'b00101), N); else n_pass++;
      n_chk++; if (ok_cnt !== 16'd1) $display("FAIL abort_next_ok got %0d exp 1", ok_cnt); else n_pass++;

      // abort coinciding with the last bit: no credit
      xfer_word(K'($urandom_range(0, 31)), 0, N - 1, got, nx, lp, fv, dc, st, tmo);
      n_chk++; if (ok_cnt !== 16'd1) $display("FAIL abort_last_ok got %0d exp 1", ok_cnt); else n_pass++;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL abort_last_valid got %b exp 0", out_valid); else n_pass++;
      exp_ok = 1;
   endtask

   task automatic test_reset_mid();
      int w;
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      in_data = K'($urandom_range(0, 31)); in_valid = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step(); step();
      n_chk++; if (out_valid !== 1'b1) $display("FAIL mid_in_shift got %b exp 1", out_valid); else n_pass++;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; out_ready = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", out_valid); else n_pass++;
      n_chk++; if (out_last !== 1'b0) $display("FAIL mid_out_last got %b exp 0", out_last); else n_pass++;
      n_chk++; if (out_bit !== 1'b0) $display("FAIL mid_out_bit got %b exp 0", out_bit); else n_pass++;
      n_chk++; if (err_pulse !== 1'b0) $display("FAIL mid_err_pulse got %b exp 0", err_pulse); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got %b exp 1", in_ready); else n_pass++;
      n_chk++; if (ok_cnt !== 16'd0) $display("FAIL mid_ok_cnt got %0d exp 0", ok_cnt); else n_pass++;
      n_chk++; if (b_err_cnt !== 2'd0) $display("FAIL mid_err_cnt got %0d exp 0", b_err_cnt); else n_pass++;
      exp_ok = 0;
   endtask

   task automatic test_back_to_back();
      bit q[$];
      int acc, a1, a2;
      logic [2*N-1:0] got2, exp2;
      logic [N-1:0] got;
      int nx, lp, fv, dc;
      bit st, tmo;
      do_reset();
      in_valid = 1'b1; in_data = 5'b11011; out_ready = 1'b1;
      acc = 0; a1 = -1; a2 = -1;
      for (int c = 0; c < 60; c++) begin
         if (acc == 2 && ok_cnt == 16'd2) break;
         if (in_valid && in_ready) begin
            if (acc == 0) a1 = c; else a2 = c;
            acc++;
         end
         if (out_valid && out_ready) q.push_back(out_bit);
         step();
         if (acc == 1) in_data = 5'b10000;
         if (acc == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      got2 = '0;
      foreach (q[i]) got2 = {got2[2*N-2:0], q[i]};
      exp2 = {gold(5'b11011), gold(5'b10000)};
      n_chk++; if (a2 - a1 != N + 2) $display("FAIL b2b_spacing got %0d exp %0d", a2 - a1, N + 2); else n_pass++;
      n_chk++; if (ok_cnt !== 16'd2) $display("FAIL b2b_ok_cnt got %0d exp 2", ok_cnt); else n_pass++;
      n_chk++; if (q.size() != 2 * N) $display("FAIL b2b_nbits got %0d exp %0d", q.size(), 2 * N); else n_pass++;
      n_chk++; if (got2 !== exp2) $display("FAIL b2b_stream got %b exp %b", got2, exp2); else n_pass++;

      for (int w = 0; w < 2; w++)
         xfer_word(K'($urandom_range(0, 31)), 0, -1, got, nx, lp, fv, dc, st, tmo);
      n_chk++; if (ok_cnt !== 16'd4) $display("FAIL sat_main_ok got %0d exp 4", ok_cnt); else n_pass++;
      n_chk++; if (s_ok_cnt !== 2'd3) $display("FAIL ok_cnt_saturate got %0d exp 3", s_ok_cnt); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      test_reset();
      test_single();
      test_stall();
      test_bad_syndrome();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
